// File: rtl/act_pwl_stream.sv
`timescale 1ns/1ps
// act_pwl_stream: streaming sigmoid/tanh of a signed fixed-point sample.
// Uses the shift-add PLAN sigmoid; tanh(x) = 2*sig(2x) - 1, with a per-sample mode.
// Three-stage valid/ready pipeline; the tag rides along unchanged.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready/in_data/in_mode/in_tag   input stream (mode 0 = sigmoid, 1 = tanh)
//   out_valid/out_ready/out_data/out_tag       result stream
module act_pwl_stream #(
    parameter int IN_W     = 8,
    parameter int IN_FRAC  = 4,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = 6,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);
    localparam int ZW = IN_W + 1;
    localparam int FW = IN_FRAC + 5;
    localparam int YW = FW + 1;
    localparam int SH = FW - OUT_FRAC;

    // Constants at FW fractional bits, thresholds at IN_FRAC bits.
    localparam logic [31:0] ONE   = 32'(1) << FW;
    localparam logic [31:0] HALF  = (32'(1) << SH) >> 1;
    localparam logic [31:0] T_SAT = 32'(5) << IN_FRAC;
    // 2.375 = 19/8, compared against 8*z so it stays exact
    localparam logic [31:0] T_MID = 32'(19) << IN_FRAC;
    localparam logic [31:0] T_ONE = 32'(1) << IN_FRAC;
    // 0.84375 = 27/32
    localparam logic [31:0] C_HI  = 32'(27) << IN_FRAC;
    localparam logic [31:0] C_MID = 32'(5) << (FW - 3);
    localparam logic [31:0] C_LO  = 32'(1) << (FW - 1);
    localparam int MAXV = 2 ** (OUT_W - 1) - 1;
    localparam int MINV = -(2 ** (OUT_W - 1));

    logic             s1_valid_q, s1_valid_d;
    logic [ZW-1:0]    s1_z_q, s1_z_d;
    logic             s1_neg_q, s1_neg_d;
    logic             s1_mode_q, s1_mode_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [YW-1:0]    s2_y_q, s2_y_d;
    logic             s2_neg_q, s2_neg_d;
    logic             s2_mode_q, s2_mode_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             s1_adv, s2_adv, out_adv;
    logic [IN_W-1:0]  abs_x;
    logic [31:0]      z32, y32, y3, mag, rmag;
    logic             neg;
    int               sval;

    assign out_adv   = ~out_valid_q | out_ready;
    assign s2_adv    = ~s2_valid_q | out_adv;
    assign s1_adv    = ~s1_valid_q | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

    // Stage 1: |x| (-2^(IN_W-1) maps exactly to 2^(IN_W-1)), doubled for tanh
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_z_d     = s1_z_q;
        s1_neg_d   = s1_neg_q;
        s1_mode_d  = s1_mode_q;
        s1_tag_d   = s1_tag_q;
        abs_x      = in_data[IN_W-1] ? (~in_data + 1'b1) : in_data;
        if (s1_adv) s1_valid_d = in_valid;
        if (s1_adv && in_valid) begin
            s1_z_d    = in_mode ? {abs_x, 1'b0} : {1'b0, abs_x};
            s1_neg_d  = in_data[IN_W-1];
            s1_mode_d = in_mode;
            s1_tag_d  = in_tag;
        end
    end

    // Stage 2: PLAN sigmoid of z >= 0; z/32 at FW bits is z's raw value
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_y_d     = s2_y_q;
        s2_neg_d   = s2_neg_q;
        s2_mode_d  = s2_mode_q;
        s2_tag_d   = s2_tag_q;
        z32        = 32'(s1_z_q);
        if (z32 >= T_SAT)             y32 = ONE;
        else if ((z32 << 3) >= T_MID) y32 = z32 + C_HI;
        else if (z32 >= T_ONE)        y32 = (z32 << 2) + C_MID;
        else                          y32 = (z32 << 3) + C_LO;
        if (s2_adv) s2_valid_d = s1_valid_q;
        if (s2_adv && s1_valid_q) begin
            s2_y_d    = YW'(y32);
            s2_neg_d  = s1_neg_q;
            s2_mode_d = s1_mode_q;
            s2_tag_d  = s1_tag_q;
        end
    end

    // Stage 3: fold sign, round magnitude half-up (= ties away from zero), saturate
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        y3          = 32'(s2_y_q);
        if (s2_mode_q) begin
            // y >= 0.5 since z >= 0, so this never underflows
            mag = (y3 << 1) - ONE;
            neg = s2_neg_q;
        end else begin
            mag = s2_neg_q ? (ONE - y3) : y3;
            neg = 1'b0;
        end
        rmag = (mag + HALF) >> SH;
        sval = neg ? -int'(rmag) : int'(rmag);
        if (sval > MAXV) sval = MAXV;
        if (sval < MINV) sval = MINV;
        if (out_adv) out_valid_d = s2_valid_q;
        if (out_adv && s2_valid_q) begin
            out_data_d = OUT_W'(sval);
            out_tag_d  = s2_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_z_q      <= '0;
            s1_neg_q    <= 1'b0;
            s1_mode_q   <= 1'b0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_y_q      <= '0;
            s2_neg_q    <= 1'b0;
            s2_mode_q   <= 1'b0;
            s2_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_z_q      <= s1_z_d;
            s1_neg_q    <= s1_neg_d;
            s1_mode_q   <= s1_mode_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_y_q      <= s2_y_d;
            s2_neg_q    <= s2_neg_d;
            s2_mode_q   <= s2_mode_d;
            s2_tag_q    <= s2_tag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end
endmodule

// File: tb/tb_act_pwl_stream.sv
`timescale 1ns/1ps
// Bench for act_pwl_stream (default Q3.4 in, Q1.6 out).
// Scoreboard of expected results, checked as results emerge.
module tb_act_pwl_stream;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_mode;
    logic [3:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_tag;

    act_pwl_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int sb_d[$];
    int sb_t[$];
    int cur_exp;
    int exp_rdy;
    int cyc = 0;
    int first_in;
    int first_out;
    logic [3:0] tg = 4'd0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: real arithmetic, exact for these dyadic values
    function automatic int model(input logic [7:0] x, input bit mode);
        real xv, z, y, r, m;
        int q;
        xv = real'($signed(x)) / 16.0;
        z  = (xv < 0.0 ? -xv : xv) * (mode ? 2.0 : 1.0);
        if (z >= 5.0)        y = 1.0;
        else if (z >= 2.375) y = z / 32.0 + 0.84375;
        else if (z >= 1.0)   y = z / 8.0 + 0.625;
        else                 y = z / 4.0 + 0.5;
        if (!mode) r = (xv >= 0.0) ? y : 1.0 - y;
        else begin
            r = 2.0 * y - 1.0;
            if (xv < 0.0) r = -r;
        end
        m = (r < 0.0) ? -r : r;
        q = int'($floor(m * 64.0 + 0.5));
        if (r < 0.0) q = -q;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    // One clock: observe at negedge, then advance to just past posedge
    task automatic step(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready && !rst;
        if (exp_rdy >= 0) check_eq("in_ready", int'(in_ready), exp_rdy);
        if (acc) begin
            sb_d.push_back(cur_exp);
            sb_t.push_back(int'(in_tag));
            if (first_in < 0) first_in = cyc;
        end
        if (out_valid) begin
            if (first_out < 0) first_out = cyc;
            if (sb_d.size() == 0) begin
                check_eq("spurious_out", 1, 0);
            end else begin
                check_eq("data", int'($signed(out_data)), sb_d[0]);
                check_eq("tag", int'(out_tag), sb_t[0]);
                if (out_ready && !rst) begin
                    void'(sb_d.pop_front());
                    void'(sb_t.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [7:0] x, input bit mode, input int exp);
        bit acc;
        int c;
        in_valid = 1'b1;
        in_data  = x;
        in_mode  = mode;
        in_tag   = tg;
        cur_exp  = exp;
        acc = 1'b0;
        c = 0;
        while (!acc && c < 50) begin
            step(acc);
            c++;
        end
        if (!acc) check_eq("send_timeout", 0, 1);
        tg++;
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb_d.size() > 0; c++) step(acc);
        check_eq("drain_left", sb_d.size(), 0);
    endtask

    logic [7:0] dx[16] = '{8'h00, 8'h01, 8'h10, 8'h28, 8'h11, 8'h10, 8'hF0, 8'h80,
                           8'h7F, 8'h7F, 8'h80, 8'h10, 8'h10, 8'hF0, 8'hF0, 8'h10};
    bit         dm[16] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0};
    int         de[16] = '{32, 33, 48, 59, 49, 48, -48, 0,
                           64, 64, -64, 48, 48, 16, -48, 48};
    logic [7:0] bx[4]  = '{8'h05, 8'hE3, 8'h30, 8'h9A};

    initial begin
        bit acc;
        int k;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        in_mode = 1'b0;
        in_tag = 4'h0;
        out_ready = 1'b1;
        cur_exp = 0;
        exp_rdy = -1;
        first_in = -1;
        first_out = -1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_data", int'(out_data), 0);
        check_eq("rst_out_tag", int'(out_tag), 0);
        check_eq("rst_in_ready", int'(in_ready), 1);

        // Directed back-to-back stream: values, rounding, extremes, mode toggling
        for (int i = 0; i < 16; i++) send(dx[i], dm[i], de[i]);
        drain();
        check_eq("latency", first_out - first_in, 3);

        // Backpressure: out_ready low 5 cycles, 4 samples offered
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = bx[k];
            in_mode  = k[0];
            in_tag   = 4'(8 + k);
            cur_exp  = model(bx[k], k[0]);
            exp_rdy  = (c >= 3) ? 0 : 1;
            step(acc);
            if (acc) k++;
        end
        exp_rdy = -1;
        check_eq("bp_held", k, 3);
        out_ready = 1'b1;
        for (int c = 0; c < 10 && k < 4; c++) begin
            in_valid = 1'b1;
            in_data  = bx[k];
            in_mode  = k[0];
            in_tag   = 4'(8 + k);
            cur_exp  = model(bx[k], k[0]);
            step(acc);
            if (acc) k++;
        end
        check_eq("bp_sent", k, 4);
        drain();

        // Random valid/ready stream with a mid-stream reset
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                rst = 1'b1;
                in_valid = 1'b0;
                out_ready = 1'b0;
                step(acc);
                rst = 1'b0;
                sb_d.delete();
                sb_t.delete();
                check_eq("rst_mid_out_valid", int'(out_valid), 0);
                check_eq("rst_mid_in_ready", int'(in_ready), 1);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_mode   = 1'($urandom);
            in_tag    = tg;
            cur_exp   = model(in_data, in_mode);
            out_ready = (i >= 145 && i < 150) ? 1'b0 : ($urandom_range(0, 3) != 0);
            step(acc);
            if (acc) tg++;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
